// File: rtl/uart_tx_param.sv
// ----------------------------------------------------------------------------
// uart_tx_param -- parameterised UART transmitter (8N1-style framing).
//
// Frame on TX_Pin_Out: start bit (0), DATA_BITS data bits LSB first,
// optional parity bit, STOP_BITS stop bits (1). Every bit lasts exactly
// BAUD_DIV CLK cycles.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   : PARITY state compiled in, parity bit sent after the data
//               (even when PARITY_ODD=0, odd when PARITY_ODD=1)
//   undefined : DATA goes straight to STOP, PARITY_ODD is ignored
//
// Parameters:
//   BAUD_DIV   CLK cycles per bit (2..65535)
//   DATA_BITS  data bits per frame (5..9)
//   STOP_BITS  stop bits per frame (1 or 2)
//   PARITY_ODD parity sense, only meaningful with UART_TX_PARITY_EN
//
// Ports:
//   CLK          system clock
//   Rstn         asynchronous active-low reset
//   TX_En_Sig    transmit enable; low freezes the frame in place
//   TX_Valid     TX_Data holds a word to send
//   TX_Data      payload word
//   TX_Ready     block accepts a word (transfer = TX_Valid & TX_Ready)
//   TX_Busy      a frame is in progress
//   TX_Done_Sig  one-cycle pulse during the last cycle of the frame
//   TX_Pin_Out   serial line, idle high
//
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module uart_tx_param #(
    parameter int BAUD_DIV   = 434,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 CLK,
    input  logic                 Rstn,
    input  logic                 TX_En_Sig,
    input  logic                 TX_Valid,
    input  logic [DATA_BITS-1:0] TX_Data,
    output logic                 TX_Ready,
    output logic                 TX_Busy,
    output logic                 TX_Done_Sig,
    output logic                 TX_Pin_Out
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (BAUD_DIV < 2 || BAUD_DIV > 65535) begin : g_bad_baud
        $error("uart_tx_param: BAUD_DIV out of range 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
        $error("uart_tx_param: DATA_BITS out of range 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
        $error("uart_tx_param: PARITY_ODD must be 0 or 1");
    end

    // ------------------------------------------------------------------
    // Widths and terminal counts
    // ------------------------------------------------------------------
    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
    // One cycle before the bit boundary: used to raise TX_Done_Sig so that
    // the registered pulse lines up with the final stop-bit cycle.
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(BAUD_DIV - 2);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;     // baud counter, 0..BAUD_DIV-1
    logic [IDX_W-1:0]     idx_q;     // data bit index, reused as stop bit index
    logic [DATA_BITS-1:0] sh_q;      // latched word, shifted right per bit
    logic                 pin_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 done_q;
`ifdef UART_TX_PARITY_EN
    logic                 par_q;     // parity computed once at latch time
`endif

    // ------------------------------------------------------------------
    // Next-value helpers
    // ------------------------------------------------------------------
    logic             bit_end;
    logic [CNT_W-1:0] cnt_d;
    logic             done_d;

    assign bit_end = (cnt_q == CNT_LAST);
    assign cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);
    assign done_d  = (state_q == STOP) && (idx_q == STOP_LAST) &&
                     (cnt_q == CNT_PRE);

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge Rstn) begin
        if (!Rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            pin_q   <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else if (state_q == IDLE) begin
            done_q <= 1'b0;
            if (TX_Valid && ready_q) begin
                // Transfer: latch the word, start bit goes out on this edge.
                sh_q    <= TX_Data;
`ifdef UART_TX_PARITY_EN
                par_q   <= (^TX_Data) ^ (PARITY_ODD != 0);
`endif
                cnt_q   <= '0;
                idx_q   <= '0;
                pin_q   <= 1'b0;
                state_q <= START;
                busy_q  <= 1'b1;
                ready_q <= 1'b0;
            end else begin
                ready_q <= TX_En_Sig;
            end
        end else if (TX_En_Sig) begin
            // While disabled nothing in this branch runs, so state, counters,
            // line level and a pending done pulse are all frozen in place.
            cnt_q  <= cnt_d;
            done_q <= done_d;
            if (bit_end) begin
                case (state_q)
                    START: begin
                        state_q <= DATA;
                        idx_q   <= '0;
                        pin_q   <= sh_q[0];
                        sh_q    <= sh_q >> 1;
                    end
                    DATA: begin
                        if (idx_q == IDX_LAST) begin
                            idx_q <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            pin_q   <= par_q;
`else
                            state_q <= STOP;
                            pin_q   <= 1'b1;
`endif
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                            pin_q <= sh_q[0];
                            sh_q  <= sh_q >> 1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        state_q <= STOP;
                        idx_q   <= '0;
                        pin_q   <= 1'b1;
                    end
`endif
                    STOP: begin
                        if (idx_q == STOP_LAST) begin
                            // Frame complete; enable is known high here, so
                            // the next word can be taken on the following edge.
                            state_q <= IDLE;
                            idx_q   <= '0;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                        pin_q <= 1'b1;
                    end
                    default: begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        pin_q   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign TX_Ready    = ready_q;
    assign TX_Busy     = busy_q;
    assign TX_Done_Sig = done_q;
    assign TX_Pin_Out  = pin_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// ----------------------------------------------------------------------------
// Bench for uart_tx_param. Two instances share control inputs:
//   u0: BAUD_DIV=4, DATA_BITS=8, STOP_BITS=1, PARITY_ODD=0
//   u1: BAUD_DIV=4, DATA_BITS=5, STOP_BITS=2, PARITY_ODD=1
// A frame-position model (list of line bits per frame plus a cycle index)
// predicts every output every cycle; literal expectations pin the model.
// ----------------------------------------------------------------------------
module tb_uart_tx_param;

    localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] d0 = '0;
    logic [4:0] d1 = '0;
    logic rdy0, bsy0, dn0, pin0;
    logic rdy1, bsy1, dn1, pin1;

    always #5 clk = ~clk;

    uart_tx_param #(.BAUD_DIV(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u0 (
        .CLK(clk), .Rstn(rstn), .TX_En_Sig(en), .TX_Valid(valid), .TX_Data(d0),
        .TX_Ready(rdy0), .TX_Busy(bsy0), .TX_Done_Sig(dn0), .TX_Pin_Out(pin0));

    uart_tx_param #(.BAUD_DIV(4), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(1)) u1 (
        .CLK(clk), .Rstn(rstn), .TX_En_Sig(en), .TX_Valid(valid), .TX_Data(d1),
        .TX_Ready(rdy1), .TX_Busy(bsy1), .TX_Done_Sig(dn1), .TX_Pin_Out(pin1));

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // ---------------- model ----------------
    int db [2] = '{8, 5};
    int sb [2] = '{1, 2};
    int po [2] = '{0, 1};
    bit m_busy [2];
    bit m_ready [2];
    int m_t [2];
    int m_len [2];
    bit m_bits [2][0:15];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_ready[i] = 0; m_t[i] = 0;
        end
    endtask

    task automatic model_load(input int i, input int dv);
        bit par;
        int n;
        m_bits[i][0] = 0;
        par = bit'(po[i]);
        for (int j = 0; j < db[i]; j++) begin
            m_bits[i][1+j] = bit'((dv >> j) & 1);
            par ^= m_bits[i][1+j];
        end
        n = 1 + db[i];
        if (P == 1) begin m_bits[i][n] = par; n++; end
        for (int s = 0; s < sb[i]; s++) m_bits[i][n+s] = 1;
        m_len[i] = BD * (n + sb[i]);
    endtask

    task automatic model_step();
        if (!rstn) model_reset();
        else for (int i = 0; i < 2; i++) begin
            if (!m_busy[i]) begin
                if (valid && m_ready[i]) begin
                    model_load(i, (i == 0) ? int'(d0) : int'(d1));
                    m_busy[i] = 1; m_t[i] = 0; m_ready[i] = 0;
                end else m_ready[i] = en;
            end else if (en) begin
                if (m_t[i] == m_len[i] - 1) begin m_busy[i] = 0; m_ready[i] = 1; end
                else m_t[i]++;
            end
        end
    endtask

    task automatic cmp_inst(input int i, input logic p, input logic b, input logic d, input logic r);
        int ep;
        ep = m_busy[i] ? int'(m_bits[i][m_t[i] / BD]) : 1;
        check($sformatf("u%0d pin", i), p, ep);
        check($sformatf("u%0d busy", i), b, m_busy[i]);
        check($sformatf("u%0d done", i), d, m_busy[i] && (m_t[i] == m_len[i] - 1));
        check($sformatf("u%0d ready", i), r, m_ready[i]);
    endtask

    task automatic compare_all();
        cmp_inst(0, pin0, bsy0, dn0, rdy0);
        cmp_inst(1, pin1, bsy1, dn1, rdy1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        compare_all();
    endtask

    // ---------------- per-frame sample records ----------------
    logic s0 [0:127];
    logic s1 [0:127];
    int k0, k1, n0, n1;

    task automatic clr();
        k0 = 0; k1 = 0; n0 = 0; n1 = 0;
    endtask

    task automatic sample(input int k);
        s0[k] = pin0; s1[k] = pin1;
        if (dn0) begin n0++; if (k0 == 0) k0 = k; end
        if (dn1) begin n1++; if (k1 == 0) k1 = k; end
    endtask

    int lit_np [10] = '{0,1,0,1,0,0,1,0,1,1};
    int lit_p  [11] = '{0,1,0,1,0,0,1,0,1,0,1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e;
        model_reset();

        // Reset state
        repeat (3) tick();
        check("reset pin", pin0, 1);
        check("reset ready", rdy0, 0);
        check("reset busy u1", bsy1, 0);
        check("reset done", dn0, 0);

        rstn = 1; en = 1;
        tick();
        check("ready after release u0", rdy0, 1);
        check("ready after release u1", rdy1, 1);

        // Frame check: 0xA5 on u0, 0x1F on u1
        clr(); d0 = 8'hA5; d1 = 5'h1F; valid = 1;
        for (int k = 1; k <= 45; k++) begin
            tick(); sample(k);
            if (k == 1) valid = 0;
        end
        for (int j = 0; j < 10 + P; j++) begin
            e = (P == 1) ? lit_p[j] : lit_np[j];
            check($sformatf("A5 bit%0d first", j), s0[4*j+1], e);
            check($sformatf("A5 bit%0d last", j), s0[4*j+4], e);
        end
        check("A5 done cycle", k0, 40 + 4*P);
        check("A5 done count", n0, 1);
        check("1F start", s1[1], 0);
        check("1F start end", s1[4], 0);
        check("1F data first", s1[5], 1);
        check("1F data last", s1[24], 1);
        check("1F stop last", s1[32+4*P], 1);
        check("1F done cycle", k1, 32 + 4*P);

        // Parity check word 0x07
        clr(); d0 = 8'h07; d1 = 5'h07; valid = 1;
        for (int k = 1; k <= 48; k++) begin
            tick(); sample(k);
            if (k == 1) valid = 0;
        end
`ifdef UART_TX_PARITY_EN
        check("par even 07", s0[37], 1);
        check("par even 07 end", s0[40], 1);
        check("par odd 07", s1[25], 0);
        check("par frame len", k0, 44);
`else
        check("07 frame len", k0, 40);
        check("07 last data", s0[36], 0);
`endif

        // Back-to-back, data changes mid-frame are ignored
        clr(); d0 = 8'h01; d1 = 5'h01; valid = 1;
        for (int k = 1; k <= 95; k++) begin
            tick(); sample(k);
            if (k == 1) begin d0 = 8'h80; d1 = 5'h10; end
            if (k == 42 + 4*P) valid = 0;
        end
        check("b2b done count u0", n0, 2);
        check("b2b done count u1", n1, 2);
        check("b2b last stop", s0[40+4*P], 1);
        check("b2b idle gap", s0[41+4*P], 1);
        check("b2b next start", s0[42+4*P], 0);
        check("b2b 80 bit6", s0[70+4*P], 0);
        check("b2b 80 bit7", s0[74+4*P], 1);

        // Pause 10 cycles during data bit 3
        clr(); d0 = 8'hA5; d1 = 5'h1F; valid = 1;
        for (int k = 1; k <= 60; k++) begin
            tick(); sample(k);
            if (k == 1) valid = 0;
            if (k == 18) en = 0;
            if (k == 28) en = 1;
        end
        check("pause bit2", s0[16], 1);
        check("pause bit3 stretched", s0[30], 0);
        check("pause bit4 end", s0[34], 0);
        check("pause bit5 start", s0[35], 1);
        check("pause done u0", k0, 50 + 4*P);
        check("pause done u1", k1, 42 + 4*P);

        // Reset mid-frame during data bit 4
        clr(); d0 = 8'hA5; valid = 1;
        for (int k = 1; k <= 21; k++) begin
            tick(); sample(k);
            if (k == 1) valid = 0;
        end
        rstn = 0;
        model_reset();
        #1;
        compare_all();
        check("rst pin", pin0, 1);
        check("rst busy", bsy0, 0);
        check("rst ready", rdy0, 0);
        for (int k = 22; k <= 23; k++) begin tick(); sample(k); end
        rstn = 1;
        tick(); sample(24);
        check("rst ready after release", rdy0, 1);
        for (int k = 25; k <= 30; k++) begin tick(); sample(k); end
        check("rst no done", n0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
